// File: rtl/ebi_cmd_packer.sv
// Assembles five 16-bit EBI writes into one 80-bit {time, addr, data} scheduler
// command and pushes it into command_fifo, with backpressure, ordering checks and timeout.
module ebi_cmd_packer #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [15:0]      wr_data,
  output logic [79:0]      fifo_din,
  output logic             fifo_wr_en,
  input  logic             fifo_full,
  output logic             busy,
  input  logic             clear_err,
  output logic             err_overflow,
  output logic             err_order,
  output logic             err_timeout,
  output logic [CNT_W-1:0] cmd_count
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CMD_W  = 80;
  localparam int unsigned TMO_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(4);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PENDING = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         exp_q, exp_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic [3:0][WORD_W-1:0]   hold_q, hold_d;
  logic [CMD_W-1:0]         din_q, din_d;
  logic                     push_q, push_d;
  logic                     busy_q, busy_d;
  logic                     ovf_q, ovf_d;
  logic                     ord_q, ord_d;
  logic                     tmo_err_q, tmo_err_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic set_ovf, set_ord, set_tmo, accept, tmo_fire;

  // Next-state, word capture, commit and sticky error logic
  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    tmo_d    = tmo_q;
    hold_d   = hold_q;
    din_d    = din_q;
    push_d   = 1'b0;
    busy_d   = 1'b0;
    cnt_d    = cnt_q;
    set_ovf  = 1'b0;
    set_ord  = 1'b0;
    set_tmo  = 1'b0;
    accept   = 1'b0;
    // Fires on the TIMEOUT-th cycle since the last accepted word; takes precedence over a write
    tmo_fire = (TIMEOUT != 0) && (state_q == ST_COLLECT) &&
               (tmo_q == TMO_W'(TIMEOUT - 1));

    unique case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (tmo_fire) begin
          set_tmo = 1'b1;
          state_d = ST_IDLE;
          exp_d   = '0;
        end
        if (wr_en) begin
          if ((state_q == ST_COLLECT) && !tmo_fire && (wr_addr == exp_q)) begin
            accept = 1'b1;
          end else if (wr_addr == '0) begin
            accept  = 1'b1;
            set_ord = (state_q == ST_COLLECT) && !tmo_fire;
          end else begin
            set_ord = 1'b1;
            state_d = ST_IDLE;
            exp_d   = '0;
          end
        end

        if (accept) begin
          tmo_d = '0;
          if (wr_addr == LAST_IDX) begin
            din_d = {hold_q[1], hold_q[0], hold_q[2], wr_data, hold_q[3]};
            exp_d = '0;
            if (fifo_full) begin
              state_d = ST_PENDING;
              busy_d  = 1'b1;
            end else begin
              state_d = ST_IDLE;
              push_d  = 1'b1;
              cnt_d   = cnt_q + CNT_W'(1);
            end
          end else begin
            hold_d[wr_addr[1:0]] = wr_data;
            exp_d   = IDX_W'(wr_addr + IDX_W'(1));
            state_d = ST_COLLECT;
          end
        end else if ((state_d == ST_COLLECT) && (TIMEOUT != 0)) begin
          tmo_d = tmo_q + TMO_W'(1);
        end else begin
          tmo_d = '0;
        end
      end

      ST_PENDING: begin
        tmo_d   = '0;
        set_ovf = wr_en;
        busy_d  = fifo_full;
        if (!fifo_full) begin
          state_d = ST_IDLE;
          push_d  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        exp_d   = '0;
        tmo_d   = '0;
      end
    endcase

    ovf_d     = set_ovf | (ovf_q & ~clear_err);
    ord_d     = set_ord | (ord_q & ~clear_err);
    tmo_err_d = set_tmo | (tmo_err_q & ~clear_err);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      exp_q     <= '0;
      tmo_q     <= '0;
      hold_q    <= '0;
      din_q     <= '0;
      push_q    <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ord_q     <= 1'b0;
      tmo_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      tmo_q     <= tmo_d;
      hold_q    <= hold_d;
      din_q     <= din_d;
      push_q    <= push_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
      ord_q     <= ord_d;
      tmo_err_q <= tmo_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign fifo_din     = din_q;
  assign fifo_wr_en   = push_q;
  assign busy         = busy_q;
  assign err_overflow = ovf_q;
  assign err_order    = ord_q;
  assign err_timeout  = tmo_err_q;
  assign cmd_count    = cnt_q;

endmodule

// File: tb/tb_ebi_cmd_packer.sv
// Self-checking bench for ebi_cmd_packer: directed scenarios plus random traffic
// compared every cycle against a queue-based command model.
module tb_ebi_cmd_packer;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [2:0]       wr_addr;
  logic [15:0]      wr_data;
  logic [79:0]      fifo_din;
  logic             fifo_wr_en;
  logic             fifo_full;
  logic             busy;
  logic             clear_err;
  logic             err_overflow;
  logic             err_order;
  logic             err_timeout;
  logic [CNT_W-1:0] cmd_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ebi_cmd_packer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .fifo_din     (fifo_din),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_full    (fifo_full),
    .busy         (busy),
    .clear_err    (clear_err),
    .err_overflow (err_overflow),
    .err_order    (err_order),
    .err_timeout  (err_timeout),
    .cmd_count    (cmd_count)
  );

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the words accepted so far for the command being built, plus the pending command
  logic [15:0] m_part[$];
  logic [79:0] m_din;
  bit          m_push, m_pend, m_ovf, m_ord, m_tmo, m_live;
  int          m_cnt, m_since;

  // Advance the model with the inputs sampled at the last posedge, then compare
  always @(negedge clk) begin : model_cmp
    bit s_ovf, s_ord, s_tmo, acc;
    if (!rst) begin
      m_part.delete();
      m_din = '0; m_push = 0; m_pend = 0;
      m_ovf = 0; m_ord = 0; m_tmo = 0;
      m_cnt = 0; m_since = 0; m_live = 1;
    end else if (m_live) begin
      s_ovf = 0; s_ord = 0; s_tmo = 0; acc = 0; m_push = 0;
      if (m_pend) begin
        if (wr_en) s_ovf = 1;
        if (!fifo_full) begin
          m_pend = 0;
          m_push = 1;
          m_cnt  = (m_cnt + 1) % (1 << CNT_W);
        end
      end else begin
        if (TIMEOUT > 0 && m_part.size() > 0 && m_since + 1 >= TIMEOUT) begin
          s_tmo = 1;
          m_part.delete();
        end
        if (wr_en) begin
          if (int'(wr_addr) == m_part.size()) begin
            m_part.push_back(wr_data);
            acc = 1;
          end else begin
            s_ord = 1;
            m_part.delete();
            if (wr_addr == 3'd0) begin
              m_part.push_back(wr_data);
              acc = 1;
            end
          end
        end
        if (m_part.size() == 5) begin
          m_din = {m_part[1], m_part[0], m_part[2], m_part[4], m_part[3]};
          m_part.delete();
          if (fifo_full) m_pend = 1;
          else begin
            m_push = 1;
            m_cnt  = (m_cnt + 1) % (1 << CNT_W);
          end
        end
        m_since = acc ? 0 : m_since + 1;
      end
      m_ovf = s_ovf | (m_ovf & !clear_err);
      m_ord = s_ord | (m_ord & !clear_err);
      m_tmo = s_tmo | (m_tmo & !clear_err);
    end
    if (m_live) begin
      chk("cmp_push",    80'(fifo_wr_en),   80'(m_push));
      chk("cmp_din",     fifo_din,          m_din);
      chk("cmp_busy",    80'(busy),         80'(m_pend));
      chk("cmp_err_ovf", 80'(err_overflow), 80'(m_ovf));
      chk("cmp_err_ord", 80'(err_order),    80'(m_ord));
      chk("cmp_err_tmo", 80'(err_timeout),  80'(m_tmo));
      chk("cmp_count",   80'(cmd_count),    80'(m_cnt));
    end
  end

  task automatic cyc(input logic en, input logic [2:0] a, input logic [15:0] d,
                     input logic full = 1'b0, input logic clr = 1'b0, input logic r = 1'b1);
    wr_en = en; wr_addr = a; wr_data = d;
    fifo_full = full; clear_err = clr; rst = r;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic full = 1'b0);
    repeat (n) cyc(1'b0, 3'd0, 16'h0000, full);
  endtask

  task automatic do_reset();
    cyc(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cmd(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                     input logic [15:0] w3, input logic [15:0] w4, input logic full_last);
    cyc(1'b1, 3'd0, w0);
    cyc(1'b1, 3'd1, w1);
    cyc(1'b1, 3'd2, w2);
    cyc(1'b1, 3'd3, w3);
    cyc(1'b1, 3'd4, w4, full_last);
  endtask

  initial begin
    wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0000;
    fifo_full = 1'b0; clear_err = 1'b0; rst = 1'b0;

    do_reset();
    chk("rst_push",  80'(fifo_wr_en), 80'(1'b0));
    chk("rst_din",   fifo_din,        80'h0);
    chk("rst_count", 80'(cmd_count),  80'(0));

    // Basic command, FIFO has room
    cmd(16'h1234, 16'h0000, 16'h00F1, 16'hBEEF, 16'hDEAD, 1'b0);
    chk("t1_push",  80'(fifo_wr_en), 80'(1'b1));
    chk("t1_din",   fifo_din,        80'h0000_1234_00F1_DEAD_BEEF);
    chk("t1_count", 80'(cmd_count),  80'(1));
    chk("t1_errs",  80'({err_overflow, err_order, err_timeout}), 80'(0));
    idle(1);
    chk("t1_single", 80'(fifo_wr_en), 80'(1'b0));

    // Backpressure with an overflow write while busy
    do_reset();
    cmd(16'h1234, 16'h0000, 16'h00F1, 16'hBEEF, 16'hDEAD, 1'b1);
    chk("t2_busy0", 80'(busy), 80'(1'b1));
    for (int i = 0; i < 9; i++) begin
      cyc(i == 4, 3'd0, 16'hFFFF, 1'b1);
      chk("t2_busy", 80'(busy), 80'(1'b1));
      chk("t2_nopush", 80'(fifo_wr_en), 80'(1'b0));
    end
    chk("t2_ovf", 80'(err_overflow), 80'(1'b1));
    idle(1);
    chk("t2_push",  80'(fifo_wr_en), 80'(1'b1));
    chk("t2_busy_fall", 80'(busy),   80'(1'b0));
    chk("t2_din",   fifo_din,        80'h0000_1234_00F1_DEAD_BEEF);
    chk("t2_count", 80'(cmd_count),  80'(1));
    idle(1);
    chk("t2_single", 80'(fifo_wr_en), 80'(1'b0));

    // Skipped index, then a clean command, then clear_err
    do_reset();
    cyc(1'b1, 3'd0, 16'hAAAA);
    cyc(1'b1, 3'd1, 16'hBBBB);
    cyc(1'b1, 3'd3, 16'hCCCC);
    chk("t3_ord", 80'(err_order), 80'(1'b1));
    cmd(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 1'b0);
    chk("t3_push", 80'(fifo_wr_en), 80'(1'b1));
    chk("t3_din",  fifo_din,        80'h2222_1111_3333_5555_4444);
    cyc(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1);
    chk("t3_clr", 80'(err_order), 80'(1'b0));

    // Restart at index 0 mid-command
    do_reset();
    cyc(1'b1, 3'd0, 16'hA000);
    cyc(1'b1, 3'd1, 16'hA001);
    cmd(16'hB000, 16'hB001, 16'h0022, 16'h3333, 16'h4444, 1'b0);
    chk("t4_ord",   80'(err_order),  80'(1'b1));
    chk("t4_din",   fifo_din,        80'hB001_B000_0022_4444_3333);
    chk("t4_count", 80'(cmd_count),  80'(1));

    // Timeout after eight idle cycles, then an out-of-order write
    do_reset();
    cyc(1'b1, 3'd0, 16'h0101);
    cyc(1'b1, 3'd1, 16'h0202);
    idle(7);
    chk("t5_tmo_early", 80'(err_timeout), 80'(1'b0));
    idle(1);
    chk("t5_tmo",    80'(err_timeout), 80'(1'b1));
    chk("t5_nopush", 80'(cmd_count),   80'(0));
    cyc(1'b1, 3'd2, 16'h0303);
    chk("t5_ord", 80'(err_order), 80'(1'b1));

    // Write landing on the timeout cycle starts a fresh command
    do_reset();
    cyc(1'b1, 3'd0, 16'h1000);
    idle(7);
    cyc(1'b1, 3'd0, 16'h7777);
    chk("t5b_tmo", 80'(err_timeout), 80'(1'b1));
    chk("t5b_ord", 80'(err_order),   80'(1'b0));
    cyc(1'b1, 3'd1, 16'h7001);
    cyc(1'b1, 3'd2, 16'h7002);
    cyc(1'b1, 3'd3, 16'h7003);
    cyc(1'b1, 3'd4, 16'h7004);
    chk("t5b_din", fifo_din, 80'h7001_7777_7002_7004_7003);

    // Counter wrap, then reset mid-command
    do_reset();
    for (int i = 0; i < 17; i++)
      cmd(16'(i), 16'h0001, 16'h0002, 16'h0003, 16'(i + 100), 1'b0);
    chk("t6_wrap", 80'(cmd_count), 80'(1));
    cyc(1'b1, 3'd5, 16'hEEEE);
    chk("t6_ord", 80'(err_order), 80'(1'b1));
    cyc(1'b1, 3'd0, 16'h0A0A);
    cyc(1'b1, 3'd1, 16'h0B0B);
    cyc(1'b1, 3'd2, 16'h0C0C);
    cyc(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("t6_rst_din",   fifo_din,        80'h0);
    chk("t6_rst_count", 80'(cmd_count),  80'(0));
    chk("t6_rst_errs",  80'({err_overflow, err_order, err_timeout, busy, fifo_wr_en}), 80'(0));
    cmd(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 1'b0);
    chk("t6_push",  80'(fifo_wr_en), 80'(1'b1));
    chk("t6_din",   fifo_din,        80'h0002_0001_0003_0005_0004);
    chk("t6_count", 80'(cmd_count),  80'(1));

    // Random traffic, mostly in-order to complete commands
    for (int i = 0; i < 4000; i++) begin
      logic       en, full, clr, r;
      logic [2:0] a;
      en   = ($urandom_range(0, 99) < 60);
      a    = ($urandom_range(0, 99) < 85) ? 3'(m_part.size()) : 3'($urandom_range(0, 7));
      full = ($urandom_range(0, 99) < 25);
      clr  = ($urandom_range(0, 99) < 4);
      r    = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 99) < 3) idle($urandom_range(6, 12), full);
      cyc(en, a, 16'($urandom), full, clr, r);
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ebi_cmd_packer.md
Name: ebi_cmd_packer

Overview:
Sits between the EBI interface and command_fifo. Collects five 16-bit EBI writes into one 80-bit scheduler command {time, cmd_bus_addr, cmd_bus_data} and pushes it into command_fifo with a single-cycle write strobe. Provides backpressure, ordering checks, a partial-command timeout and a committed-command counter so firmware can detect lost commands.

Parameters:
CNT_W, 16, width of committed-command counter
TIMEOUT, 0, cycles of write inactivity in COLLECT before the partial command is discarded; 0 disables the timeout

Ports:
clk  in  1  system clock (sys_clk domain)
rst  in  1  synchronous reset, active-low
wr_en  in  1  one-cycle pulse per accepted EBI write to the command window
wr_addr  in  3  word index within the command window, 0..4
wr_data  in  16  EBI write data
fifo_din  out  80  packed command to command_fifo
fifo_wr_en  out  1  one-cycle push strobe to command_fifo
fifo_full  in  1  command_fifo full flag
busy  out  1  high while a completed command waits for FIFO space
clear_err  in  1  one-cycle pulse that clears the sticky error flags
err_overflow  out  1  sticky: write dropped while busy
err_order  out  1  sticky: out-of-order or invalid word index
err_timeout  out  1  sticky: partial command discarded by timeout
cmd_count  out  CNT_W  number of commands pushed, wraps

Behaviour:
- Reset (rst==0 at posedge clk): state=IDLE, fifo_wr_en=0, fifo_din=0, busy=0, all err_*=0, cmd_count=0, expected index=0, timeout counter=0. Reset wins over every other input.
- Word map: 0=time[15:0], 1=time[31:16], 2=addr[15:0], 3=data[15:0], 4=data[31:16].
- Packing: fifo_din[79:48]=time, [47:32]=addr, [31:0]=data.
- States: IDLE, COLLECT, PENDING.
- IDLE: wr_en with wr_addr==0 -> latch word, expected=1, go to COLLECT. Any other wr_addr -> err_order set, write dropped, stay in IDLE.
- COLLECT: wr_en with wr_addr==expected -> latch word, expected+1.
  - wr_addr==0 (restart) -> discard partial, latch word 0, expected=1, err_order set.
  - Any other index, including 5..7 -> err_order set, partial discarded, go to IDLE.
- Commit: accepted word 4 in cycle N.
  - fifo_full==0 in cycle N -> fifo_wr_en=1 and fifo_din valid in cycle N+1, cmd_count+1 in N+1, state -> IDLE.
  - fifo_full==1 in cycle N -> state PENDING, busy=1 from N+1.
- PENDING: fifo_din held stable. First cycle with fifo_full==0 -> fifo_wr_en pulses the next cycle, busy falls in that same cycle, cmd_count increments, state -> IDLE. Any wr_en during PENDING is dropped and sets err_overflow. No partial command is accepted.
- fifo_wr_en is never high for more than one cycle per command. fifo_din changes only on commit.
- Timeout: applies only in COLLECT and only when TIMEOUT>0. The counter resets on every accepted write. When it reaches TIMEOUT, the partial command is discarded, err_timeout is set and state -> IDLE. A write arriving in the same cycle the timeout fires is treated as an IDLE-state write.
- Error flags: set and clear_err in the same cycle -> set wins.
- cmd_count wraps from 2^CNT_W-1 to 0 without any flag.
- An incoming word is latched into a holding register for its index, overwriting the previous contents. Holding registers are not cleared on discard.

Test Plan:
- Words 0x1234, 0x0000, 0x00F1, 0xBEEF, 0xDEAD to indices 0..4, fifo_full=0 -> one fifo_wr_en pulse the cycle after word 4; fifo_din=0x00001234_00F1_DEADBEEF; cmd_count=1; no errors.
- Same sequence with fifo_full=1 for 10 cycles after word 4 -> busy=1 for those cycles and no push. A write during busy sets err_overflow. After fifo_full falls, a single push of the unchanged command occurs; busy=0; cmd_count=1.
- Indices 0, 1, 3 -> err_order=1, state IDLE, no push. Then a full 0..4 sequence -> pushes correctly. clear_err -> err_order=0.
- Indices 0, 1, 0, 1, 2, 3, 4 -> err_order=1; exactly one push, carrying the second word 0 and word 1 values.
- TIMEOUT=8: indices 0, 1, then idle 8 cycles -> err_timeout=1, no push. Then a write to index 2 -> err_order=1.
- CNT_W=4: 17 complete commands -> cmd_count=1. Assert rst=0 mid-sequence (after word 2) -> all outputs at reset values; next full sequence pushes normally.
